// File: rtl/button_counter_pkg.sv
// Shared types and helpers for the multi-channel button counter.
// Holds the debounce state encoding, the digit width and BCD +/-1 helpers.
package button_counter_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_W      = DIGIT_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    // BCD +1 over the low ndig digits; a digit at 9 rolls to 0 and carries on.
    function automatic logic [MAX_W-1:0] bcd_inc(input logic [MAX_W-1:0] v, input int ndig);
        logic [MAX_W-1:0] r;
        logic             carry;
        logic [3:0]       d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            d = r[i*DIGIT_W +: DIGIT_W];
            if (i < ndig && carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[i*DIGIT_W +: DIGIT_W] = d;
        end
        return r;
    endfunction

    // BCD -1 over the low ndig digits; a digit at 0 rolls to 9 and borrows on.
    function automatic logic [MAX_W-1:0] bcd_dec(input logic [MAX_W-1:0] v, input int ndig);
        logic [MAX_W-1:0] r;
        logic             borrow;
        logic [3:0]       d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            d = r[i*DIGIT_W +: DIGIT_W];
            if (i < ndig && borrow) begin
                if (d == 4'd0) begin
                    d = 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*DIGIT_W +: DIGIT_W] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_counter_multi_debounce.sv
// btn_debounce: 2-flop synchronizer + debounce FSM producing a registered
// one-cycle press pulse, DEBOUNCE_CYCLES+2 edges after a stable high input.
// With COUNT_AUTO_REPEAT_EN defined, a repeat timer re-fires the pulse while
// the button stays HELD (only when REPEAT_EN is nonzero).
module btn_debounce
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_nxt;
    logic          rpt_hit;

    assign level = sync[1];

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], btn_raw};
    end

    // FSM state, stability counter and registered press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // Next state: a level is accepted only after DEBOUNCE_CYCLES matching samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (level) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!level) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (!level)       state_nxt = RELEASE_WAIT;
                else if (rpt_hit) press_nxt = 1'b1;
            end
            RELEASE_WAIT: begin
                if (level) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef COUNT_AUTO_REPEAT_EN
    logic [31:0] rpt_cnt, rpt_lim;

    assign rpt_hit = (REPEAT_EN != 0) && (state == HELD) && level && (rpt_cnt == rpt_lim);

    // Repeat timer: first re-fire REPEAT_DELAY after entering HELD, then every REPEAT_PERIOD.
    always_ff @(posedge clk) begin
        if (reset || state != HELD) begin
            rpt_cnt <= '0;
            rpt_lim <= 32'(REPEAT_DELAY - 1);
        end else if (rpt_hit) begin
            rpt_cnt <= '0;
            rpt_lim <= 32'(REPEAT_PERIOD - 1);
        end else begin
            rpt_cnt <= rpt_cnt + 32'd1;
        end
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{32'(REPEAT_EN), 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rpt_hit = 1'b0;
`endif

endmodule

// File: rtl/button_counter_multi.sv
// button_counter_multi: NUM_CHANNELS independent up/down counters (HEX or BCD)
// driven by debounced buttons, with a shared clear. Optional auto-repeat on
// up/down is enabled by defining COUNT_AUTO_REPEAT_EN.
module button_counter_multi
    import button_counter_pkg::*;
#(
    parameter string MODE            = "HEX",
    parameter int    NUM_DIGITS      = 4,
    parameter int    NUM_CHANNELS    = 2,
    parameter int    DEBOUNCE_CYCLES = 256,
    parameter int    WRAP            = 1,
    parameter int    REPEAT_DELAY    = 50000000,
    parameter int    REPEAT_PERIOD   = 10000000
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_CHANNELS-1:0]                          btn_up,
    input  logic [NUM_CHANNELS-1:0]                          btn_down,
    input  logic                                             btn_clr,
    output logic [NUM_CHANNELS-1:0][NUM_DIGITS-1:0][DIGIT_W-1:0] encoded,
    output logic [NUM_CHANNELS-1:0][NUM_DIGITS-1:0]          digit_point,
    output logic [NUM_CHANNELS-1:0]                          limit_pulse
);

    localparam bit IS_DEC = (MODE == "DEC");
    localparam int CNT_W  = NUM_DIGITS * DIGIT_W;
    // BCD mode supports up to MAX_DIGITS digits.
    localparam logic [CNT_W-1:0] MAX_CNT = IS_DEC ? {NUM_DIGITS{4'h9}} : {NUM_DIGITS{4'hF}};

    logic [NUM_CHANNELS-1:0] up_p, dn_p;
    logic                    clr_p;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(0),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_clr (.clk(clk), .reset(reset), .btn_raw(btn_clr), .press(clr_p));

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0]      cnt, cnt_inc, cnt_dec;
        logic [NUM_DIGITS-1:0] dp;
        logic                  lim;

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1),
            .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_up (.clk(clk), .reset(reset), .btn_raw(btn_up[c]), .press(up_p[c]));

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1),
            .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_dn (.clk(clk), .reset(reset), .btn_raw(btn_down[c]), .press(dn_p[c]));

        assign cnt_inc = IS_DEC ? CNT_W'(bcd_inc(MAX_W'(cnt), NUM_DIGITS)) : cnt + CNT_W'(1);
        assign cnt_dec = IS_DEC ? CNT_W'(bcd_dec(MAX_W'(cnt), NUM_DIGITS)) : cnt - CNT_W'(1);

        // Count update: clear wins, opposing presses cancel, limits wrap or saturate.
        always_ff @(posedge clk) begin
            if (reset || clr_p) begin
                cnt <= '0;
                lim <= 1'b0;
            end else begin
                lim <= 1'b0;
                if (up_p[c] && !dn_p[c]) begin
                    if (cnt == MAX_CNT) begin
                        lim <= 1'b1;
                        if (WRAP != 0) cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else if (dn_p[c] && !up_p[c]) begin
                    if (cnt == '0) begin
                        lim <= 1'b1;
                        if (WRAP != 0) cnt <= MAX_CNT;
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
            end
        end

        // Decimal point of digit 0 flags a saturated channel sitting at a limit.
        always_comb begin
            dp    = '1;
            dp[0] = !((WRAP == 0) && (cnt == '0 || cnt == MAX_CNT));
        end

        assign encoded[c]     = cnt;
        assign digit_point[c] = dp;
        assign limit_pulse[c] = lim;
    end

endmodule

// File: tb/tb_button_counter_multi.sv
// Scoreboard bench: two DUTs (DEC/wrap and HEX/saturate, 2 digits, 2 channels,
// debounce 4) share the button stimulus. Expected count/limit events are queued
// per DUT; a monitor pops one entry whenever a DUT's encoded value changes or a
// limit pulse is seen.
module tb_button_counter_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_up = 2'b00, btn_down = 2'b00;
    logic       btn_clr = 1'b0;
    logic [15:0] enc_a, enc_b;
    logic [3:0]  dp_a, dp_b;
    logic [1:0]  lim_a, lim_b;

    always #5 clk = ~clk;

    button_counter_multi #(
        .MODE("DEC"), .NUM_DIGITS(2), .NUM_CHANNELS(2), .DEBOUNCE_CYCLES(4),
        .WRAP(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_dut_a (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .encoded(enc_a), .digit_point(dp_a), .limit_pulse(lim_a)
    );

    button_counter_multi #(
        .MODE("HEX"), .NUM_DIGITS(2), .NUM_CHANNELS(2), .DEBOUNCE_CYCLES(4),
        .WRAP(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) u_dut_b (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .encoded(enc_b), .digit_point(dp_b), .limit_pulse(lim_b)
    );

    typedef struct packed {
        logic [15:0] enc;
        logic [1:0]  lim;
    } exp_t;

    exp_t        q [2][$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [15:0] prev [2];
    logic [15:0] m_enc;
    logic [1:0]  m_lim;
    exp_t        m_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect2(input logic [15:0] ea, input logic [1:0] la,
                           input logic [15:0] eb, input logic [1:0] lb);
        exp_t t;
        t.enc = ea; t.lim = la; q[0].push_back(t);
        t.enc = eb; t.lim = lb; q[1].push_back(t);
    endtask

    task automatic press(input logic [1:0] up, input logic [1:0] dn, input logic clr, input int hold);
        @(negedge clk);
        btn_up = up; btn_down = dn; btn_clr = clr;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        btn_up = 2'b00; btn_down = 2'b00; btn_clr = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    // Monitor: any count change or limit pulse must match the next queued event.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                m_enc = (d == 0) ? enc_a : enc_b;
                m_lim = (d == 0) ? lim_a : lim_b;
                if (m_enc != prev[d] || m_lim != 2'b00) begin
                    checks++;
                    if (q[d].size() == 0) begin
                        errors++;
                        $display("FAIL event dut%0d: got enc=%h lim=%b, expected no event", d, m_enc, m_lim);
                    end else begin
                        m_e = q[d].pop_front();
                        if (m_e.enc !== m_enc || m_e.lim !== m_lim) begin
                            errors++;
                            $display("FAIL event dut%0d: got enc=%h lim=%b, expected enc=%h lim=%b",
                                     d, m_enc, m_lim, m_e.enc, m_e.lim);
                        end
                    end
                end
                prev[d] = m_enc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int va;
        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_enc_a", enc_a, 16'h0000);
        chk("reset_enc_b", enc_b, 16'h0000);
        chk("reset_lim_a", lim_a, 2'b00);
        chk("reset_lim_b", lim_b, 2'b00);
        chk("reset_dp_a", dp_a, 4'b1111);
        chk("reset_dp_b", dp_b, 4'b1010);
        reset = 1'b0;
        prev[0] = 16'h0000;
        prev[1] = 16'h0000;
        mon_en = 1'b1;

        // First increment and its latency (update 7 edges after the first sampling edge)
        expect2(16'h0001, 2'b00, 16'h0001, 2'b00);
        @(negedge clk);
        btn_up = 2'b01;
        repeat (7) @(posedge clk);
        #1 chk("latency_before_update", enc_a, 16'h0000);
        @(posedge clk);
        #1 chk("latency_update", enc_a, 16'h0001);
        repeat (12) @(posedge clk);
        @(negedge clk);
        btn_up = 2'b00;
        repeat (12) @(posedge clk);
        chk("dp_a_mid", dp_a, 4'b1111);
        chk("dp_b_mid", dp_b, 4'b1011);

        // Down to 0, down at 0 (wrap vs saturate), up at 99, down at 0
        expect2(16'h0000, 2'b00, 16'h0000, 2'b00); press(2'b00, 2'b01, 1'b0, 10);
        expect2(16'h0099, 2'b01, 16'h0000, 2'b01); press(2'b00, 2'b01, 1'b0, 10);
        expect2(16'h0000, 2'b01, 16'h0001, 2'b00); press(2'b01, 2'b00, 1'b0, 10);
        expect2(16'h0099, 2'b01, 16'h0000, 2'b00); press(2'b00, 2'b01, 1'b0, 10);
        chk("dp_b_at_zero", dp_b, 4'b1010);

        // Walk channel 0 of the HEX DUT up to 0xFF; DEC DUT rolls through 00 three times
        for (int k = 1; k <= 255; k++) begin
            va = (99 + k) % 100;
            expect2({8'h00, 4'(va / 10), 4'(va % 10)}, (va == 0) ? 2'b01 : 2'b00,
                    {8'h00, 8'(k)}, 2'b00);
            press(2'b01, 2'b00, 1'b0, 8);
        end
        // Up at 0xFF with saturation: count holds, limit pulses
        expect2(16'h0055, 2'b00, 16'h00FF, 2'b01); press(2'b01, 2'b00, 1'b0, 10);
        chk("sat_hold_b", enc_b, 16'h00FF);
        chk("dp_b_at_max", dp_b, 4'b1010);
        chk("dp_a_wrap", dp_a, 4'b1111);

        // 3-cycle glitch on up[1]: no event
        @(negedge clk);
        btn_up = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_up = 2'b00;
        repeat (12) @(posedge clk);
        // Simultaneous up/down on channel 1: cancel
        press(2'b10, 2'b10, 1'b0, 10);
        chk("glitch_cancel_a", enc_a, 16'h0055);
        chk("glitch_cancel_b", enc_b, 16'h00FF);

        // Clear and up[0] qualifying together: clear wins on all channels
        expect2(16'h0155, 2'b00, 16'h01FF, 2'b00); press(2'b10, 2'b00, 1'b0, 10);
        expect2(16'h0000, 2'b00, 16'h0000, 2'b00); press(2'b01, 2'b00, 1'b1, 10);
        chk("clr_dp_b", dp_b, 4'b1010);

        // Reset mid-PRESS_WAIT with the button released during reset: no count
        expect2(16'h0100, 2'b00, 16'h0100, 2'b00); press(2'b10, 2'b00, 1'b0, 10);
        expect2(16'h0000, 2'b00, 16'h0000, 2'b00);
        @(negedge clk);
        btn_up = 2'b01;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; btn_up = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        chk("reset_discard_a", enc_a, 16'h0000);

        // Button held through reset re-qualifies and counts once
        expect2(16'h0001, 2'b00, 16'h0001, 2'b00);
        @(negedge clk);
        btn_up = 2'b01;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        btn_up = 2'b00;
        repeat (14) @(posedge clk);
        chk("held_through_reset_b", enc_b, 16'h0001);

`ifdef COUNT_AUTO_REPEAT_EN
        // Auto-repeat: first pulse plus repeats at +20,+25,+30,+35
        for (int v = 2; v <= 6; v++) expect2({8'h00, 8'(v)}, 2'b00, {8'h00, 8'(v)}, 2'b00);
        @(negedge clk);
        btn_up = 2'b01;
        repeat (42) @(posedge clk);
        @(negedge clk);
        btn_up = 2'b00;
        repeat (14) @(posedge clk);
        chk("repeat_total_a", enc_a, 16'h0006);
`endif

        repeat (5) @(posedge clk);
        chk("queue_a_drained", q[0].size(), 0);
        chk("queue_b_drained", q[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
